i2c_init_sequencer: RTL and testbench
=====================================

I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_WRITES, 8: table entries, 1..16.
- MAX_RETRIES, 3: retries per entry after its first attempt, 0..7.
- GAP_CYCLES, 1000: idle cycles after each successful write, 1..2^20-1.
- WATCHDOG_CYCLES, 500000: per-attempt timeout, 1..2^20-1.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-low reset (one clock; reset is synchronous and active-low).
- go, in, 1: start-sequence pulse.
- tbl_index, out, 4: table entry select.
- tbl_dev_address, in, 7: combinational table read data.
- tbl_reg_address, in, 8: combinational table read data.
- tbl_data, in, 8: combinational table read data.
- wr_dev_address, out, 7: to write engine.
- wr_reg_address, out, 8: to write engine.
- wr_data, out, 8: to write engine.
- wr_start, out, 1: one-cycle start pulse to write engine.
- wr_reset, out, 1: active-high reset to write engine.
- wr_done, in, 1: write engine success pulse.
- wr_failure, in, 1: write engine failure pulse.
- busy, out, 1: sequence in progress.
- init_done, out, 1: all entries written.
- init_failed, out, 1: sequence aborted.
- fail_index, out, 4: entry that exhausted its retries.
- state_out, out, 4: state encoding, for debug.

Function
REQ-003 States and encodings: IDLE=0, LOAD=1, START=2, WAIT=3, RECOVER=4, GAP=5, DONE=6, FAIL=7; all other codes go to IDLE next cycle.
REQ-004 IDLE, DONE, FAIL: go=1 -> LOAD; idx, retry count, init_done, init_failed and fail_index all cleared.
REQ-005 LOAD (1 cycle): tbl_index=idx; latch tbl_* into wr_* registers; -> START.
REQ-006 START (1 cycle): wr_start=1; clear watchdog counter; -> WAIT. wr_start SHALL be 0 in every other state.
REQ-007 WAIT, priority order:
- wr_failure -> failure path (takes priority over a simultaneous wr_done);
- else watchdog reached WATCHDOG_CYCLES-1 -> failure path;
- else wr_done -> clear retry count, clear gap counter, -> GAP;
- else increment watchdog.
REQ-008 Failure path:
- retry < MAX_RETRIES -> retry++, -> RECOVER.
- Otherwise -> FAIL, fail_index=idx.
REQ-009 RECOVER (1 cycle): wr_reset=1; clear gap counter; -> GAP; idx unchanged, so the same entry is retried.
REQ-010 GAP: count to GAP_CYCLES-1, then branch:
- entry was retried and has not yet succeeded -> LOAD, same idx;
- idx==NUM_WRITES-1 -> DONE;
- otherwise idx++ -> LOAD.
REQ-011 Retry tracking: a 1-bit "pending retry" flag is set in RECOVER and cleared on wr_done; GAP reads it to decide between retry and advance.
REQ-012 busy=1 in LOAD, START, WAIT, RECOVER and GAP; 0 elsewhere.
REQ-013 init_done=1 only in DONE. init_failed=1 only in FAIL. fail_index holds its value until the next go.
REQ-014 go is ignored while busy=1.
REQ-015 wr_done or wr_failure arriving outside WAIT is ignored.
REQ-016 Counter widths: watchdog and gap counters 20 bits; retry 3 bits; idx 4 bits; idx never exceeds NUM_WRITES-1.
REQ-017 tbl_index=idx in every state.
REQ-018 All outputs are registered except tbl_index and state_out, which are taken directly from registers.

Reset
REQ-019 reset=0 at a clock edge forces, from any state including mid-write:
- state=IDLE;
- idx=0, retry=0, pending flag=0;
- wr_* address and data = 0, wr_start=0;
- wr_reset=1 while reset=0, and 0 on the first cycle after release;
- busy=0, init_done=0, init_failed=0, fail_index=0.
REQ-020 Reset overrides go and all other inputs in the same cycle.

Verification
REQ-021 Happy path: NUM_WRITES=3, GAP_CYCLES=4; go; engine pulses wr_done 10 cycles after each wr_start.
- Expect three wr_start pulses with wr_* matching table entries 0, 1, 2.
- Expect exactly 4 gap cycles after each wr_done.
- Expect init_done=1 and busy=0 after the third gap.
REQ-022 Retry then succeed: wr_failure on the first attempt of entry 1, wr_done on the second.
- Expect one wr_reset pulse, the same wr_reg_address reissued, then advance to entry 2.
- Expect init_failed=0 at the end.
REQ-023 Exhaustion: MAX_RETRIES=2, engine always pulses wr_failure on entry 2.
- Expect exactly 3 wr_start pulses for entry 2.
- Expect state FAIL, init_failed=1, fail_index=2, no further wr_start.
REQ-024 Watchdog and simultaneous events:
- WATCHDOG_CYCLES=50, engine silent: expect a failure path exactly 50 cycles after wr_start.
- wr_done and wr_failure in the same cycle: expect RECOVER, not GAP.
REQ-025 Reset and go handling:
- reset=0 asserted during WAIT on entry 1: expect IDLE and all outputs at reset values next cycle; then go restarts at entry 0.
- go pulsed while busy: expect no effect.
- go pulsed in DONE: expect a full restart.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a register-write table through an external I2C
// write engine at power-up. Each entry is loaded, started, watched by a
// per-attempt watchdog and retried with an engine reset on failure. A fixed
// idle gap follows every successful write and every recovery. The sequence
// ends in DONE when all entries succeed, or in FAIL with the offending entry
// index when one entry runs out of retries.
//
// Handshake with the write engine: wr_start is a one-cycle request. The
// engine answers with a one-cycle wr_done or wr_failure pulse. Responses are
// only honoured while waiting on an attempt. wr_failure beats a simultaneous
// wr_done.
module i2c_init_sequencer #(
    parameter int NUM_WRITES      = 8,
    parameter int MAX_RETRIES     = 3,
    parameter int GAP_CYCLES      = 1000,
    parameter int WATCHDOG_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    output logic [3:0] tbl_index,
    input  logic [6:0] tbl_dev_address,
    input  logic [7:0] tbl_reg_address,
    input  logic [7:0] tbl_data,
    output logic [6:0] wr_dev_address,
    output logic [7:0] wr_reg_address,
    output logic [7:0] wr_data,
    output logic       wr_start,
    output logic       wr_reset,
    input  logic       wr_done,
    input  logic       wr_failure,
    output logic       busy,
    output logic       init_done,
    output logic       init_failed,
    output logic [3:0] fail_index,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_START   = 4'd2,
        ST_WAIT    = 4'd3,
        ST_RECOVER = 4'd4,
        ST_GAP     = 4'd5,
        ST_DONE    = 4'd6,
        ST_FAIL    = 4'd7
    } state_t;

    localparam logic [19:0] WD_LAST   = 20'(WATCHDOG_CYCLES - 1);
    localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST  = 4'(NUM_WRITES - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  retry_q, retry_d;
    logic        pending_q, pending_d;
    logic [19:0] wd_q, wd_d;
    logic [19:0] gap_q, gap_d;
    logic [6:0]  wr_dev_q, wr_dev_d;
    logic [7:0]  wr_reg_q, wr_reg_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_start_q, wr_start_d;
    logic        wr_reset_q, wr_reset_d;
    logic        busy_q, busy_d;
    logic        init_done_q, init_done_d;
    logic        init_failed_q, init_failed_d;
    logic [3:0]  fail_index_q, fail_index_d;

    // Next-state and datapath: sequencing, retry bookkeeping and counters.
    // Status outputs are derived from the next state so they register in
    // step with the state they describe.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        pending_d    = pending_q;
        wd_d         = wd_q;
        gap_d        = gap_q;
        wr_dev_d     = wr_dev_q;
        wr_reg_d     = wr_reg_q;
        wr_data_d    = wr_data_q;
        fail_index_d = fail_index_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (go) begin
                    state_d      = ST_LOAD;
                    idx_d        = 4'd0;
                    retry_d      = 3'd0;
                    pending_d    = 1'b0;
                    fail_index_d = 4'd0;
                end
            end
            ST_LOAD: begin
                wr_dev_d  = tbl_dev_address;
                wr_reg_d  = tbl_reg_address;
                wr_data_d = tbl_data;
                state_d   = ST_START;
            end
            ST_START: begin
                wd_d    = 20'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_failure || (wd_q == WD_LAST)) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_RECOVER;
                    end else begin
                        fail_index_d = idx_q;
                        state_d      = ST_FAIL;
                    end
                end else if (wr_done) begin
                    retry_d   = 3'd0;
                    pending_d = 1'b0;
                    gap_d     = 20'd0;
                    state_d   = ST_GAP;
                end else begin
                    wd_d = wd_q + 20'd1;
                end
            end
            ST_RECOVER: begin
                // idx is left alone so the gap leads back to the same entry
                pending_d = 1'b1;
                gap_d     = 20'd0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (pending_q) begin
                        state_d = ST_LOAD;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    gap_d = gap_q + 20'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_start_d    = (state_d == ST_START);
        wr_reset_d    = (state_d == ST_RECOVER);
        busy_d        = (state_d == ST_LOAD) || (state_d == ST_START) ||
                        (state_d == ST_WAIT) || (state_d == ST_RECOVER) ||
                        (state_d == ST_GAP);
        init_done_d   = (state_d == ST_DONE);
        init_failed_d = (state_d == ST_FAIL);
    end

    // State register with synchronous active-low reset; the engine is held
    // in reset for as long as the sequencer is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            retry_q       <= 3'd0;
            pending_q     <= 1'b0;
            wd_q          <= 20'd0;
            gap_q         <= 20'd0;
            wr_dev_q      <= 7'd0;
            wr_reg_q      <= 8'd0;
            wr_data_q     <= 8'd0;
            wr_start_q    <= 1'b0;
            wr_reset_q    <= 1'b1;
            busy_q        <= 1'b0;
            init_done_q   <= 1'b0;
            init_failed_q <= 1'b0;
            fail_index_q  <= 4'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            pending_q     <= pending_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            wr_dev_q      <= wr_dev_d;
            wr_reg_q      <= wr_reg_d;
            wr_data_q     <= wr_data_d;
            wr_start_q    <= wr_start_d;
            wr_reset_q    <= wr_reset_d;
            busy_q        <= busy_d;
            init_done_q   <= init_done_d;
            init_failed_q <= init_failed_d;
            fail_index_q  <= fail_index_d;
        end
    end

    assign tbl_index      = idx_q;
    assign state_out      = state_q;
    assign wr_dev_address = wr_dev_q;
    assign wr_reg_address = wr_reg_q;
    assign wr_data        = wr_data_q;
    assign wr_start       = wr_start_q;
    assign wr_reset       = wr_reset_q;
    assign busy           = busy_q;
    assign init_done      = init_done_q;
    assign init_failed    = init_failed_q;
    assign fail_index     = fail_index_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: a scripted write-engine model answers each
// wr_start from a per-attempt plan; a sequence-level model turns the plan and
// the table into the expected write list, recovery count, busy duration and
// outcome. A vector table covers the named scenarios, hand sequences cover
// watchdog timing and mid-write reset, random plans cover the rest.
module tb_i2c_init_sequencer;

    localparam int N    = 3;
    localparam int MAXR = 2;
    localparam int GAP  = 4;
    localparam int WD   = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic       wr_done = 1'b0;
    logic       wr_failure = 1'b0;
    logic [3:0] tbl_index;
    logic [6:0] tbl_dev_address;
    logic [7:0] tbl_reg_address;
    logic [7:0] tbl_data;
    logic [6:0] wr_dev_address;
    logic [7:0] wr_reg_address;
    logic [7:0] wr_data;
    logic       wr_start, wr_reset, busy, init_done, init_failed;
    logic [3:0] fail_index, state_out;

    logic [6:0] tdev [16];
    logic [7:0] treg [16];
    logic [7:0] tdat [16];

    assign tbl_dev_address = tdev[tbl_index];
    assign tbl_reg_address = treg[tbl_index];
    assign tbl_data        = tdat[tbl_index];

    i2c_init_sequencer #(
        .NUM_WRITES(N), .MAX_RETRIES(MAXR), .GAP_CYCLES(GAP), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .tbl_index(tbl_index),
        .tbl_dev_address(tbl_dev_address), .tbl_reg_address(tbl_reg_address),
        .tbl_data(tbl_data), .wr_dev_address(wr_dev_address),
        .wr_reg_address(wr_reg_address), .wr_data(wr_data),
        .wr_start(wr_start), .wr_reset(wr_reset), .wr_done(wr_done),
        .wr_failure(wr_failure), .busy(busy), .init_done(init_done),
        .init_failed(init_failed), .fail_index(fail_index), .state_out(state_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    // act: 0 = done, 1 = failure, 2 = silent, 3 = done and failure together
    typedef struct { int act; int dly; } att_t;
    typedef struct {
        string name; string acts;
        int done; int failed; int fidx; int starts; int resets;
    } vec_t;

    att_t        plan_q[$];
    logic [22:0] exp_q[$];
    int total = 0, bad = 0;
    int n_starts = 0, n_resets = 0;
    bit cnt_en = 1'b0;
    int exp_busy, exp_resets, exp_done, exp_failed, exp_fidx;
    vec_t vecs[6];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // write engine model: one scripted response per observed wr_start
    initial begin : engine
        att_t a;
        forever begin
            @(negedge clk);
            if (reset && wr_start && plan_q.size() > 0) begin
                a = plan_q.pop_front();
                if (a.act != 2) begin
                    repeat (a.dly) @(negedge clk);
                    wr_done    = (a.act == 0 || a.act == 3);
                    wr_failure = (a.act == 1 || a.act == 3);
                    @(negedge clk);
                    wr_done    = 1'b0;
                    wr_failure = 1'b0;
                end
            end
        end
    end

    // scoreboard: every wr_start must carry the next expected table entry
    initial begin : scoreboard
        logic [22:0] e;
        forever begin
            @(negedge clk);
            if (reset && wr_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wr_start: got reg=%0h, want no start", wr_reg_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_fields", int'({wr_dev_address, wr_reg_address, wr_data}), int'(e));
                end
            end
            if (cnt_en && reset && wr_reset) n_resets++;
        end
    end

    // sequence-level reference: walk entries, consume one plan item per attempt
    task automatic model();
        int idx = 0, retry = 0, k = 0, act, dly, w;
        exp_busy = 0; exp_resets = 0; exp_done = 0; exp_failed = 0; exp_fidx = 0;
        exp_q.delete();
        forever begin
            act = (k < plan_q.size()) ? plan_q[k].act : 2;
            dly = (k < plan_q.size()) ? plan_q[k].dly : 0;
            k++;
            exp_q.push_back({tdev[idx], treg[idx], tdat[idx]});
            w = (act == 2) ? WD : dly;
            exp_busy += 2 + w;
            if (act == 0) begin
                exp_busy += GAP;
                retry = 0;
                if (idx == N - 1) begin exp_done = 1; break; end
                idx++;
            end else if (retry < MAXR) begin
                retry++;
                exp_resets++;
                exp_busy += 1 + GAP;
            end else begin
                exp_failed = 1;
                exp_fidx = idx;
                break;
            end
        end
    endtask

    task automatic set_plan_str(string s, int d);
        att_t a;
        plan_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            a.act = int'(s[i]) - 48;
            a.dly = d;
            plan_q.push_back(a);
        end
    endtask

    task automatic rand_table();
        for (int i = 0; i < 16; i++) begin
            tdev[i] = 7'($urandom);
            treg[i] = 8'($urandom);
            tdat[i] = 8'($urandom);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    // one full sequence; go_at>0 re-pulses go on that busy cycle (must be ignored)
    task automatic run_case(string name, int go_at);
        int cnt;
        n_starts = 0; n_resets = 0; cnt_en = 1'b1;
        pulse_go();
        chk({name, ":busy_at_go"}, busy, 1);
        chk({name, ":state_load"}, state_out, 1);
        chk({name, ":tbl_index0"}, tbl_index, 0);
        chk({name, ":done_clr"}, init_done, 0);
        chk({name, ":failed_clr"}, init_failed, 0);
        chk({name, ":fidx_clr"}, fail_index, 0);
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            go = (cnt == go_at);
            @(negedge clk);
        end
        go = 1'b0;
        chk({name, ":busy_cycles"}, cnt, exp_busy);
        chk({name, ":init_done"}, init_done, exp_done);
        chk({name, ":init_failed"}, init_failed, exp_failed);
        chk({name, ":fail_index"}, fail_index, exp_fidx);
        chk({name, ":end_state"}, state_out, exp_done ? 6 : 7);
        chk({name, ":recoveries"}, n_resets, exp_resets);
        chk({name, ":writes_left"}, exp_q.size(), 0);
        repeat (8) @(negedge clk);
        chk({name, ":state_hold"}, state_out, exp_done ? 6 : 7);
        chk({name, ":idle_busy"}, busy, 0);
        cnt_en = 1'b0;
    endtask

    initial begin : main
        int cnt;
        att_t a;
        vecs[0] = '{"happy",     "000",   1, 0, 0, 3, 0};
        vecs[1] = '{"retry_e1",  "0100",  1, 0, 0, 4, 1};
        vecs[2] = '{"exhaust_e2","00111", 0, 1, 2, 5, 2};
        vecs[3] = '{"watchdog",  "2000",  1, 0, 0, 4, 1};
        vecs[4] = '{"both_evts", "0300",  1, 0, 0, 4, 1};
        vecs[5] = '{"exhaust_e0","111",   0, 1, 0, 3, 2};
        rand_table();

        // reset state, with go held to show reset wins
        go = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst:state", state_out, 0);
        chk("rst:busy", busy, 0);
        chk("rst:wr_reset", wr_reset, 1);
        chk("rst:wr_start", wr_start, 0);
        chk("rst:wr_fields", int'({wr_dev_address, wr_reg_address, wr_data}), 0);
        chk("rst:flags", int'({init_done, init_failed, fail_index}), 0);
        go = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst:wr_reset_release", wr_reset, 0);
        chk("rst:idle_after", state_out, 0);

        // vector table
        foreach (vecs[i]) begin
            set_plan_str(vecs[i].acts, 10);
            model();
            run_case(vecs[i].name, 0);
            chk({vecs[i].name, ":vec_done"}, init_done, vecs[i].done);
            chk({vecs[i].name, ":vec_failed"}, init_failed, vecs[i].failed);
            chk({vecs[i].name, ":vec_fidx"}, fail_index, vecs[i].fidx);
            chk({vecs[i].name, ":vec_starts"}, n_starts, vecs[i].starts);
            chk({vecs[i].name, ":vec_resets"}, n_resets, vecs[i].resets);
        end

        // watchdog timing: silent engine, recovery WD+1 cycles after wr_start
        set_plan_str("2000", 10);
        model();
        pulse_go();
        cnt = 0;
        while (!wr_start && cnt < 20) begin @(negedge clk); cnt++; end
        chk("wd:start_seen", wr_start, 1);
        cnt = 0;
        while (!wr_reset && cnt < 200) begin @(negedge clk); cnt++; end
        chk("wd:cycles_to_recover", cnt, WD + 1);
        chk("wd:state_recover", state_out, 4);
        cnt = 0;
        while (busy && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("wd:done", init_done, 1);
        chk("wd:writes_left", exp_q.size(), 0);

        // reset in the middle of entry 1
        plan_q.delete();
        exp_q.delete();
        a.act = 0; a.dly = 5; plan_q.push_back(a);
        a.act = 2; a.dly = 0; plan_q.push_back(a);
        exp_q.push_back({tdev[0], treg[0], tdat[0]});
        exp_q.push_back({tdev[1], treg[1], tdat[1]});
        n_starts = 0;
        pulse_go();
        cnt = 0;
        while (n_starts < 2 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("mid:second_start", n_starts, 2);
        repeat (3) @(negedge clk);
        chk("mid:in_wait", state_out, 3);
        chk("mid:tbl_index", tbl_index, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid:state", state_out, 0);
        chk("mid:tbl_index_rst", tbl_index, 0);
        chk("mid:busy", busy, 0);
        chk("mid:wr_reset", wr_reset, 1);
        chk("mid:wr_fields", int'({wr_dev_address, wr_reg_address, wr_data, wr_start}), 0);
        chk("mid:flags", int'({init_done, init_failed, fail_index}), 0);
        plan_q.delete();
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("mid:wr_reset_release", wr_reset, 0);
        repeat (10) @(negedge clk);
        set_plan_str("000", 10);
        model();
        run_case("restart", 0);

        // random plans, tables and ignored go pulses
        for (int r = 0; r < 25; r++) begin
            rand_table();
            plan_q.delete();
            for (int j = 0; j < N * (MAXR + 1); j++) begin
                cnt = $urandom_range(0, 9);
                a.act = (cnt < 6) ? 0 : (cnt < 8) ? 1 : (cnt == 8) ? 2 : 3;
                a.dly = $urandom_range(1, 40);
                plan_q.push_back(a);
            end
            model();
            run_case($sformatf("rnd%0d", r), $urandom_range(0, 30));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #5000000;
        $display("FAIL timeout: got no finish, want finish before limit");
        $fatal(1);
    end

endmodule
